vga_frame_server: RTL and testbench

- Responder side of the VGA pixel-request interface.
- Holds a 160x120 4-bit grayscale framebuffer, loaded from an upstream pixel stream (the convolution output) through a valid/ready handshake.
- Answers each pixel request from the VGA output stage with the 4x-upscaled pixel two clocks later.
- Drives display_image so the screen shows black (or a test pattern) until a complete frame is loaded.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_frame_server_ram.sv | 22 ++
 rtl/vga_frame_server.sv | 136 +++++++++++++
 tb/tb_vga_frame_server.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame server: 160x120 4-bit framebuffer, 4x upscale to 640x480.
// Pure declarations; no timing or flow-control behaviour.
package vga_pkg;

  localparam int SRC_W       = 160;
  localparam int SRC_H       = 120;
  localparam int FB_DEPTH    = SRC_W * SRC_H;
  localparam int FB_ADDR_W   = 15;
  localparam int PIX_W       = 4;
  localparam int SCALE_SHIFT = 2;
  localparam int DISP_W      = 640;
  localparam int DISP_H      = 480;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0]     pix_t;

  typedef enum logic [1:0] {EMPTY, LOAD, SHOW} frame_state_t;

  localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_DEPTH - 1);

  // row*160 built from shifts so no multiplier is inferred
  function automatic fb_addr_t src_addr(input logic [6:0] row, input logic [7:0] col);
    fb_addr_t r;
    r = fb_addr_t'(row);
    return (r << 7) + (r << 5) + fb_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_frame_server_ram.sv
// Simple dual-port framebuffer: synchronous write, registered read, 1-clock read latency.
// No flow control; a same-address read/write in one cycle returns the old data.
module framebuffer_ram
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     wr_en,
  input  fb_addr_t wr_addr,
  input  pix_t     wr_data,
  input  logic     rd_en,
  input  fb_addr_t rd_addr,
  output pix_t     rd_data
);

  pix_t mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_frame_server.sv
// Frame loader plus 2-clock pixel responder; load_ready is high only while loading.
// Optional 32x32 checkerboard for blanked in-range requests under VGA_TEST_PATTERN_EN.
module vga_frame_server
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [PIX_W-1:0] load_pixel,
  output logic             load_ready,
  output logic             load_done,
  input  logic             new_pixel_request,
  input  logic [9:0]       new_pixel_x,
  input  logic [9:0]       new_pixel_y,
  output logic [PIX_W-1:0] grayscale_pixel,
  output logic             display_image,
  output logic             busy
);

  frame_state_t state, state_next;
  fb_addr_t     wr_addr, wr_addr_next;
  logic         wr_en;
  logic         done_next;

  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    wr_en        = 1'b0;
    done_next    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (load_start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end
      end
      LOAD: begin
        // a restart outranks a pixel arriving in the same cycle
        if (load_start) begin
          wr_addr_next = '0;
        end else if (load_valid) begin
          wr_en = 1'b1;
          if (wr_addr == LAST_ADDR) begin
            state_next   = SHOW;
            wr_addr_next = '0;
            done_next    = 1'b1;
          end else begin
            wr_addr_next = wr_addr + fb_addr_t'(1);
          end
        end
      end
      SHOW: begin
        if (load_start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end
      end
      default: begin
        state_next   = EMPTY;
        wr_addr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      wr_addr       <= '0;
      load_done     <= 1'b0;
      display_image <= 1'b0;
    end else begin
      state         <= state_next;
      wr_addr       <= wr_addr_next;
      load_done     <= done_next;
      display_image <= (state_next == SHOW);
    end
  end

  assign load_ready = (state == LOAD);
  assign busy       = (state == LOAD);

  logic     req1, in_range1, show1;
  fb_addr_t rd_addr1;
  logic     use_ram2;
  pix_t     pat2;
  pix_t     ram_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      req1      <= 1'b0;
      in_range1 <= 1'b0;
      show1     <= 1'b0;
      rd_addr1  <= '0;
      use_ram2  <= 1'b0;
    end else begin
      req1 <= new_pixel_request;
      if (new_pixel_request) begin
        rd_addr1  <= src_addr(7'(new_pixel_y >> SCALE_SHIFT), 8'(new_pixel_x >> SCALE_SHIFT));
        in_range1 <= (new_pixel_x < 10'(DISP_W)) && (new_pixel_y < 10'(DISP_H));
        show1     <= (state == SHOW);
      end
      if (req1) use_ram2 <= in_range1 && show1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic pat_bit1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_bit1 <= 1'b0;
      pat2     <= '0;
    end else begin
      if (new_pixel_request) pat_bit1 <= new_pixel_x[5] ^ new_pixel_y[5];
      if (req1) pat2 <= (in_range1 && !show1 && pat_bit1) ? '1 : '0;
    end
  end
`else
  assign pat2 = '0;
`endif

  framebuffer_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (load_pixel),
    .rd_en   (req1 && in_range1 && show1),
    .rd_addr (rd_addr1),
    .rd_data (ram_data)
  );

  // stage-2 select only moves on a request, so the output holds between requests
  assign grayscale_pixel = use_ram2 ? ram_data : pat2;

endmodule

// File: tb/tb_vga_frame_server.sv
// Self-checking bench for vga_frame_server: directed load/request sequence with random gaps and coordinates.
// Expected pixels come from a frame array and plain display-to-source arithmetic.
module tb_vga_frame_server;

  logic       clk = 1'b0;
  logic       reset, load_start, load_valid;
  logic [3:0] load_pixel;
  logic       load_ready, load_done;
  logic       new_pixel_request;
  logic [9:0] new_pixel_x, new_pixel_y;
  logic [3:0] grayscale_pixel;
  logic       display_image, busy;

  vga_frame_server dut (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .load_valid        (load_valid),
    .load_pixel        (load_pixel),
    .load_ready        (load_ready),
    .load_done         (load_done),
    .new_pixel_request (new_pixel_request),
    .new_pixel_x       (new_pixel_x),
    .new_pixel_y       (new_pixel_y),
    .grayscale_pixel   (grayscale_pixel),
    .display_image     (display_image),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         ready_bad  = 0;
  int         busy_bad   = 0;
  logic [3:0] fb [19200];
  bit         shown      = 1'b0;
  logic [3:0] last_exp   = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pix(input int x, input int y);
    if (x >= 640 || y >= 480) return 4'h0;
    if (shown) return fb[(y / 4) * 160 + (x / 4)];
`ifdef VGA_TEST_PATTERN_EN
    return (((x / 32) % 2) != ((y / 32) % 2)) ? 4'hF : 4'h0;
`else
    return 4'h0;
`endif
  endfunction

  task automatic request(input int x, input int y, input string tag);
    logic [3:0] exp;
    exp = model_pix(x, y);
    @(negedge clk);
    new_pixel_request = 1'b1;
    new_pixel_x = 10'(x);
    new_pixel_y = 10'(y);
    @(negedge clk);
    new_pixel_request = 1'b0;
    check({tag, " hold"}, 32'(grayscale_pixel), 32'(last_exp));
    @(negedge clk);
    check(tag, 32'(grayscale_pixel), 32'(exp));
    last_exp = exp;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // feeds n raster-order pixels (value = index mod 16) with random valid gaps
  task automatic stream(input int n, input string tag, output int dones);
    int acc;
    int cycles;
    acc    = 0;
    cycles = 0;
    dones  = 0;
    while (acc < n && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (load_done === 1'b1) dones++;
      if (load_ready !== 1'b1) ready_bad++;
      if (busy !== 1'b1) busy_bad++;
      if ($urandom_range(0, 7) != 0) begin
        load_valid = 1'b1;
        load_pixel = 4'(acc % 16);
        fb[acc]    = 4'(acc % 16);
        acc++;
      end else begin
        load_valid = 1'b0;
        load_pixel = 4'($urandom);
      end
    end
    if (acc < n) check({tag, " stream timeout"}, 32'(acc), 32'(n));
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_pixel = 4'h0;
    new_pixel_request = 1'b0;
    new_pixel_x = '0;
    new_pixel_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst grayscale", 32'(grayscale_pixel), 32'h0);
    check("rst display", 32'(display_image), 32'h0);
    check("rst load_ready", 32'(load_ready), 32'h0);
    check("rst load_done", 32'(load_done), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    request(0, 0, "empty req 0,0");
    request(32, 0, "empty req 32,0");
    check("empty load_ready", 32'(load_ready), 32'h0);

    // first complete frame
    pulse_start();
    check("busy after start", 32'(busy), 32'h1);
    stream(19200, "load1", dones);
    check("load1 early done", 32'(dones), 32'h0);
    check("load1 done on last", 32'(load_done), 32'h1);
    check("load1 display", 32'(display_image), 32'h1);
    check("load1 busy low", 32'(busy), 32'h0);
    check("load1 ready low", 32'(load_ready), 32'h0);
    shown = 1'b1;
    @(negedge clk);
    check("load1 done one cycle", 32'(load_done), 32'h0);

    request(5, 9, "show req 5,9");
    request(639, 479, "show req 639,479");
    request(640, 10, "oor x=640");
    request(10, 480, "oor y=480");
    for (int i = 0; i < 8; i++)
      request(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), "show rand");

    // restart from SHOW, then restart again mid-load
    pulse_start();
    shown = 1'b0;
    check("display falls", 32'(display_image), 32'h0);
    stream(100, "partial", dones);
    check("partial done", 32'(dones), 32'h0);
    request(32, 0, "req during load");
    pulse_start();
    check("busy after restart", 32'(busy), 32'h1);
    stream(19200, "load2", dones);
    check("load2 early done", 32'(dones), 32'h0);
    check("load2 done on last", 32'(load_done), 32'h1);
    check("load2 display", 32'(display_image), 32'h1);
    shown = 1'b1;
    @(negedge clk);
    check("load2 done one cycle", 32'(load_done), 32'h0);
    check("ready held in load", 32'(ready_bad), 32'h0);
    check("busy held in load", 32'(busy_bad), 32'h0);
    for (int i = 0; i < 6; i++)
      request(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), "reload rand");

    // reset part way through a load
    pulse_start();
    shown = 1'b0;
    stream(5000, "abort", dones);
    check("abort done", 32'(dones), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort ready", 32'(load_ready), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort display", 32'(display_image), 32'h0);
    check("abort load_done", 32'(load_done), 32'h0);
    @(negedge clk);
    check("abort load_done later", 32'(load_done), 32'h0);
    last_exp = 4'h0;
    request(20, 20, "post-reset req");
    request(40, 8, "post-reset req2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
